// File: rtl/crossbar_rd_arb_if.sv
// crossbar_rd_arb_if -- one AXI-style read link (AR channel + R channel).
//
// Parameters:
//   ADDR_W  AR address width
//   DATA_W  R data width
// Signals:
//   ARVALID/ARADDR/ARREADY  read address handshake
//   RVALID/RDATA/RLAST/RREADY  read data handshake
// Modports:
//   master  issues AR, consumes R (drives ARVALID, ARADDR, RREADY)
//   slave   accepts AR, produces R (drives ARREADY, RVALID, RDATA, RLAST)
interface crossbar_rd_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              ARVALID;
   logic [ADDR_W-1:0] ARADDR;
   logic              ARREADY;
   logic              RVALID;
   logic [DATA_W-1:0] RDATA;
   logic              RLAST;
   logic              RREADY;

   modport master (
      output ARVALID, ARADDR, RREADY,
      input  ARREADY, RVALID, RDATA, RLAST
   );

   modport slave (
      input  ARVALID, ARADDR, RREADY,
      output ARREADY, RVALID, RDATA, RLAST
   );
endinterface

// File: rtl/crossbar_rd_arb.sv
// crossbar_rd_arb -- two-master read arbiter in front of the crossbar sync
// stage. One read transaction outstanding at a time: IDLE arbitrates and
// captures the winning address, ADDR presents it downstream, DATA routes the
// R beats back to the granted master until the RLAST handshake.
//
// Parameters:
//   ADDR_W  AR address width (default 32)
//   DATA_W  R data width (default 64)
// Ports:
//   CLK     clock, rising edge
//   RST     asynchronous active-high reset
//   s0, s1  upstream master links (this block is their slave)
//   m       downstream link toward the crossbar sync stage
// Build option:
//   CROSSBAR_RD_ARB_RR_EN  defined   -> round-robin on a tie (port other than
//                                       last-served wins)
//                          undefined -> fixed priority, S0 wins a tie
module crossbar_rd_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic               CLK,
   input  logic               RST,
   crossbar_rd_arb_if.slave   s0,
   crossbar_rd_arb_if.slave   s1,
   crossbar_rd_arb_if.master  m
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              grant_q, grant_d;   // 0 = S0, 1 = S1
   logic              last_q, last_d;     // last port whose burst completed
   logic              any_req;
   logic              win;                // 0 = S0, 1 = S1
   logic              rready_sel;

   always_comb begin
      any_req = s0.ARVALID | s1.ARVALID;
`ifdef CROSSBAR_RD_ARB_RR_EN
      if (s0.ARVALID && s1.ARVALID) begin
         win = ~last_q;
      end else begin
         win = ~s0.ARVALID;
      end
`else
      // last_q is kept for state compatibility but never steers the grant.
      win = ~s0.ARVALID;
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      grant_d    = grant_q;
      last_d     = last_q;
      rready_sel = grant_q ? s1.RREADY : s0.RREADY;
      s0.ARREADY = 1'b0;
      s1.ARREADY = 1'b0;
      s0.RVALID  = 1'b0;
      s1.RVALID  = 1'b0;
      m.ARVALID  = 1'b0;
      m.RREADY   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // ARREADY is combinational from ARVALID, so it must also be held
            // off while RST is high, not just rely on the state register.
            if (any_req && !RST) begin
               s0.ARREADY = ~win;
               s1.ARREADY = win;
               addr_d     = win ? s1.ARADDR : s0.ARADDR;
               grant_d    = win;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            m.ARVALID = 1'b1;
            if (m.ARREADY) begin
               state_d = DATA;
            end
         end
         DATA: begin
            m.RREADY  = rready_sel;
            s0.RVALID = m.RVALID & ~grant_q;
            s1.RVALID = m.RVALID & grant_q;
            if (m.RVALID && rready_sel && m.RLAST) begin
               state_d = IDLE;
               last_d  = grant_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Address register is zero in reset, so this also meets the reset value.
   assign m.ARADDR = addr_q;

   // Data/last fan out to both masters; only the granted one sees RVALID.
   assign s0.RDATA = m.RDATA;
   assign s0.RLAST = m.RLAST;
   assign s1.RDATA = m.RDATA;
   assign s1.RLAST = m.RLAST;

endmodule

// File: tb/tb_crossbar_rd_arb.sv
// tb_crossbar_rd_arb -- self-checking bench for crossbar_rd_arb.
// A downstream model answers every AR with a 4-beat burst whose data encodes
// the address and beat number; expected beats are queued per master when a
// request is issued and popped as beats reach that master.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1-2 units after that, handshakes are observed 1 unit before the edge.
module tb_crossbar_rd_arb;
   localparam int          AW    = 32;
   localparam int          DW    = 64;
   localparam int unsigned BURST = 4;

   logic clk = 1'b0;
   logic rst;

   crossbar_rd_arb_if #(.ADDR_W(AW), .DATA_W(DW)) s0_if (), s1_if (), m_if ();

   crossbar_rd_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK (clk),
      .RST (rst),
      .s0  (s0_if),
      .s1  (s1_if),
      .m   (m_if)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [DW:0] exp0[$];
   logic [DW:0] exp1[$];
   logic [AW-1:0] ar_log[$];
   bit          stray = 1'b0;
   int unsigned beats0 = 0;
   int unsigned beats1 = 0;

   function automatic logic [DW:0] beat_word(logic [AW-1:0] a, int unsigned b);
      logic [DW-1:0] d;
      d = {a, 32'hC0DE_0000 | b};
      return {(b == BURST - 1), d};
   endfunction

   function automatic void push_burst(int port, logic [AW-1:0] a);
      for (int unsigned b = 0; b < BURST; b++) begin
         if (port == 0) exp0.push_back(beat_word(a, b));
         else           exp1.push_back(beat_word(a, b));
      end
   endfunction

   // Downstream slave: logs AR handshakes, then streams a burst.
   initial begin : downstream_model
      logic [AW-1:0] cur_addr;
      int unsigned   cur_beat;
      bit            busy, ar_hs, r_hs;
      logic [DW:0]   w;
      busy = 1'b0; cur_beat = 0; cur_addr = '0;
      m_if.RVALID = 1'b0; m_if.RDATA = '0; m_if.RLAST = 1'b0;
      forever begin
         @(negedge clk); #4;
         ar_hs = (rst === 1'b0) && m_if.ARVALID && m_if.ARREADY;
         r_hs  = (rst === 1'b0) && m_if.RVALID && m_if.RREADY && busy;
         if (ar_hs) ar_log.push_back(m_if.ARADDR);
         @(posedge clk); #1;
         if (rst) begin
            busy = 1'b0;
         end else if (ar_hs) begin
            busy = 1'b1; cur_beat = 0; cur_addr = ar_log[$];
         end else if (r_hs) begin
            if (cur_beat == BURST - 1) busy = 1'b0;
            else cur_beat++;
         end
         w = beat_word(cur_addr, cur_beat);
         if (stray) begin
            m_if.RVALID = 1'b1; m_if.RDATA = {DW{1'b1}}; m_if.RLAST = 1'b1;
         end else begin
            m_if.RVALID = busy; m_if.RDATA = w[DW-1:0]; m_if.RLAST = w[DW] & busy;
         end
      end
   end

   // Scoreboard: every beat accepted by a master must match its queue head.
   initial begin : r_monitor
      logic [DW:0] e;
      forever begin
         @(negedge clk); #4;
         if (rst === 1'b0) begin
            if (s0_if.RVALID && s0_if.RREADY) begin
               beats0++;
               vectors++;
               if (exp0.size() == 0) begin
                  miscompares++;
                  $display("FAIL s0_rbeat got %h expected no beat", s0_if.RDATA);
               end else begin
                  e = exp0.pop_front();
                  if ({s0_if.RLAST, s0_if.RDATA} !== e) begin
                     miscompares++;
                     $display("FAIL s0_rbeat got %h expected %h", {s0_if.RLAST, s0_if.RDATA}, e);
                  end
               end
            end
            if (s1_if.RVALID && s1_if.RREADY) begin
               beats1++;
               vectors++;
               if (exp1.size() == 0) begin
                  miscompares++;
                  $display("FAIL s1_rbeat got %h expected no beat", s1_if.RDATA);
               end else begin
                  e = exp1.pop_front();
                  if ({s1_if.RLAST, s1_if.RDATA} !== e) begin
                     miscompares++;
                     $display("FAIL s1_rbeat got %h expected %h", {s1_if.RLAST, s1_if.RDATA}, e);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic do_reset();
      rst = 1'b1;
      s0_if.ARVALID = 1'b0; s1_if.ARVALID = 1'b0;
      m_if.ARREADY = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp0.delete(); exp1.delete(); ar_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s0_if.ARVALID = 1'b1; s0_if.ARADDR = 32'h0000_0111;
      s1_if.ARVALID = 1'b1; s1_if.ARADDR = 32'h0000_0222;
      m_if.ARREADY = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1; #1;
         vectors++;
         if ({s0_if.ARREADY, s1_if.ARREADY, s0_if.RVALID, s1_if.RVALID, m_if.ARVALID, m_if.RREADY, m_if.ARADDR} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b_%h expected all zero",
                     {s0_if.ARREADY, s1_if.ARREADY, s0_if.RVALID, s1_if.RVALID, m_if.ARVALID, m_if.RREADY}, m_if.ARADDR);
         end
      end
      s0_if.ARVALID = 1'b0; s1_if.ARVALID = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1; #1;
      vectors++;
      if ({s0_if.ARREADY, s1_if.ARREADY, m_if.ARVALID, m_if.RREADY} !== 4'b0000) begin
         miscompares++;
         $display("FAIL idle_no_req got %b expected 0000",
                  {s0_if.ARREADY, s1_if.ARREADY, m_if.ARVALID, m_if.RREADY});
      end
      @(posedge clk); #1;
      ar_log.delete();
   endtask

   task automatic test_single_read();
      logic [AW-1:0] got;
      int unsigned   b0;
      b0 = beats0;
      s0_if.ARVALID = 1'b1; s0_if.ARADDR = 32'h0000_1000; m_if.ARREADY = 1'b1;
      push_burst(0, 32'h0000_1000);
      #1;
      vectors++;
      if ({s0_if.ARREADY, s1_if.ARREADY, m_if.ARVALID} !== 3'b100) begin
         miscompares++;
         $display("FAIL single_arready_c0 got %b expected 100", {s0_if.ARREADY, s1_if.ARREADY, m_if.ARVALID});
      end
      @(posedge clk); #1;
      s0_if.ARVALID = 1'b0;
      #1;
      vectors++;
      if ({s0_if.ARREADY, m_if.ARVALID, m_if.ARADDR} !== {1'b0, 1'b1, 32'h0000_1000}) begin
         miscompares++;
         $display("FAIL single_m_ar_c1 got %b_%b_%h expected 0_1_00001000", s0_if.ARREADY, m_if.ARVALID, m_if.ARADDR);
      end
      for (int i = 0; i < 40 && exp0.size() != 0; i++) begin
         @(posedge clk); #1; #1;
         vectors++;
         if (s1_if.RVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL single_s1_quiet got %b expected 0", s1_if.RVALID);
         end
      end
      vectors++;
      if (exp0.size() != 0 || beats0 - b0 != BURST) begin
         miscompares++;
         $display("FAIL single_burst got %0d beats expected %0d", beats0 - b0, BURST);
      end
      #1;
      vectors++;
      if ({m_if.RREADY, s0_if.RVALID, m_if.ARVALID} !== 3'b000) begin
         miscompares++;
         $display("FAIL single_idle_after got %b expected 000", {m_if.RREADY, s0_if.RVALID, m_if.ARVALID});
      end
      if (ar_log.size() != 0) got = ar_log.pop_front(); else got = 'x;
      vectors++;
      if (got !== 32'h0000_1000) begin
         miscompares++;
         $display("FAIL single_ar_log got %h expected 00001000", got);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_tie();
      logic [AW-1:0] exp_seq[$];
      logic [AW-1:0] got;
      int            grants;
      do_reset();
`ifdef CROSSBAR_RD_ARB_RR_EN
      exp_seq = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
      push_burst(0, 32'hA0); push_burst(1, 32'hB0);
      push_burst(0, 32'hA0); push_burst(1, 32'hB0);
`else
      exp_seq = '{32'hA0, 32'hA0, 32'hA0};
      push_burst(0, 32'hA0); push_burst(0, 32'hA0); push_burst(0, 32'hA0);
`endif
      m_if.ARREADY = 1'b1;
      s0_if.ARVALID = 1'b1; s0_if.ARADDR = 32'hA0;
      s1_if.ARVALID = 1'b1; s1_if.ARADDR = 32'hB0;
      grants = 0;
      for (int i = 0; i < 300 && grants < exp_seq.size(); i++) begin
         #1;
         if (s0_if.ARREADY || s1_if.ARREADY) grants++;
         @(posedge clk); #1;
      end
      s0_if.ARVALID = 1'b0; s1_if.ARVALID = 1'b0;
      for (int i = 0; i < 200 && (exp0.size() != 0 || exp1.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (grants != exp_seq.size() || exp0.size() != 0 || exp1.size() != 0) begin
         miscompares++;
         $display("FAIL tie_complete got %0d grants expected %0d", grants, exp_seq.size());
      end
      vectors++;
      if (ar_log.size() != exp_seq.size()) begin
         miscompares++;
         $display("FAIL tie_ar_count got %0d expected %0d", ar_log.size(), exp_seq.size());
      end
      for (int k = 0; k < exp_seq.size(); k++) begin
         if (ar_log.size() != 0) got = ar_log.pop_front(); else got = 'x;
         vectors++;
         if (got !== exp_seq[k]) begin
            miscompares++;
            $display("FAIL tie_ar_seq%0d got %h expected %h", k, got, exp_seq[k]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] got;
      int unsigned   b1;
      bit            rr;
      b1 = beats1;
      m_if.ARREADY = 1'b0;
      s1_if.RREADY = 1'b1;
      s1_if.ARVALID = 1'b1; s1_if.ARADDR = 32'h0000_2000;
      push_burst(1, 32'h0000_2000);
      #1;
      vectors++;
      if ({s0_if.ARREADY, s1_if.ARREADY} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_grant got %b expected 01", {s0_if.ARREADY, s1_if.ARREADY});
      end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if ({m_if.ARVALID, m_if.ARADDR, s0_if.ARREADY, s1_if.ARREADY} !== {1'b1, 32'h0000_2000, 2'b00}) begin
            miscompares++;
            $display("FAIL bp_hold%0d got %b_%h_%b expected 1_00002000_00", i,
                     m_if.ARVALID, m_if.ARADDR, {s0_if.ARREADY, s1_if.ARREADY});
         end
         @(posedge clk); #1;
      end
      m_if.ARREADY = 1'b1;
      s1_if.ARVALID = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 60 && exp1.size() != 0; i++) begin
         rr = (i % 3 != 1);
         s1_if.RREADY = rr;
         #1;
         vectors++;
         if (m_if.RREADY !== rr) begin
            miscompares++;
            $display("FAIL bp_rready_mirror got %b expected %b", m_if.RREADY, rr);
         end
         @(posedge clk); #1;
      end
      s1_if.RREADY = 1'b1;
      vectors++;
      if (exp1.size() != 0 || beats1 - b1 != BURST) begin
         miscompares++;
         $display("FAIL bp_beats got %0d expected %0d", beats1 - b1, BURST);
      end
      if (ar_log.size() != 0) got = ar_log.pop_front(); else got = 'x;
      vectors++;
      if (got !== 32'h0000_2000) begin
         miscompares++;
         $display("FAIL bp_ar_log got %h expected 00002000", got);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_data();
      logic [AW-1:0] got;
      int unsigned   b0;
      b0 = beats0;
      m_if.ARREADY = 1'b1;
      s0_if.ARVALID = 1'b1; s0_if.ARADDR = 32'h0000_3000;
      push_burst(0, 32'h0000_3000);
      @(posedge clk); #1;
      s0_if.ARVALID = 1'b0;
      for (int i = 0; i < 40 && beats0 - b0 < 2; i++) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({s0_if.ARREADY, s1_if.ARREADY, s0_if.RVALID, s1_if.RVALID, m_if.ARVALID, m_if.RREADY, m_if.ARADDR} !== '0
          || beats0 - b0 != 2) begin
         miscompares++;
         $display("FAIL rst_in_data got %b_%h beats %0d expected all zero beats 2",
                  {s0_if.ARREADY, s1_if.ARREADY, s0_if.RVALID, s1_if.RVALID, m_if.ARVALID, m_if.RREADY},
                  m_if.ARADDR, beats0 - b0);
      end
      exp0.delete();
      if (ar_log.size() != 0) got = ar_log.pop_front(); else got = 'x;
      vectors++;
      if (got !== 32'h0000_3000) begin
         miscompares++;
         $display("FAIL rst_ar_log got %h expected 00003000", got);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      stray = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1; #1;
         vectors++;
         if ({s0_if.RVALID, s1_if.RVALID, m_if.RREADY, m_if.ARVALID} !== 4'b0000) begin
            miscompares++;
            $display("FAIL stray_blocked got %b expected 0000",
                     {s0_if.RVALID, s1_if.RVALID, m_if.RREADY, m_if.ARVALID});
         end
      end
      stray = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      s1_if.ARVALID = 1'b1; s1_if.ARADDR = 32'h0000_4000;
      push_burst(1, 32'h0000_4000);
      #1;
      vectors++;
      if ({s0_if.ARREADY, s1_if.ARREADY} !== 2'b01) begin
         miscompares++;
         $display("FAIL post_rst_grant got %b expected 01", {s0_if.ARREADY, s1_if.ARREADY});
      end
      @(posedge clk); #1;
      s1_if.ARVALID = 1'b0;
      for (int i = 0; i < 40 && exp1.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (exp1.size() != 0) begin
         miscompares++;
         $display("FAIL post_rst_drain got %0d left expected 0", exp1.size());
      end
      if (ar_log.size() != 0) got = ar_log.pop_front(); else got = 'x;
      vectors++;
      if (got !== 32'h0000_4000) begin
         miscompares++;
         $display("FAIL post_rst_ar_log got %h expected 00004000", got);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_isolation();
      logic [AW-1:0] got;
      m_if.ARREADY = 1'b1;
      s0_if.ARVALID = 1'b1; s0_if.ARADDR = 32'h0000_5000;
      push_burst(0, 32'h0000_5000);
      @(posedge clk); #1;
      s0_if.ARVALID = 1'b0;
      s1_if.ARVALID = 1'b1; s1_if.ARADDR = 32'h0000_6000;
      push_burst(1, 32'h0000_6000);
      for (int i = 0; i < 40 && exp0.size() != 0; i++) begin
         #1;
         vectors++;
         if ({s1_if.ARREADY, s1_if.RVALID} !== 2'b00) begin
            miscompares++;
            $display("FAIL iso_s1_blocked got %b expected 00", {s1_if.ARREADY, s1_if.RVALID});
         end
         @(posedge clk); #1;
      end
      #1;
      vectors++;
      if ({exp0.size() == 0, s1_if.ARREADY} !== 2'b11) begin
         miscompares++;
         $display("FAIL iso_s1_next_idle got %b expected 1 (s0 left %0d)", s1_if.ARREADY, exp0.size());
      end
      @(posedge clk); #1;
      s1_if.ARVALID = 1'b0;
      #1;
      vectors++;
      if ({m_if.ARVALID, m_if.ARADDR} !== {1'b1, 32'h0000_6000}) begin
         miscompares++;
         $display("FAIL iso_b2b_ar got %b_%h expected 1_00006000", m_if.ARVALID, m_if.ARADDR);
      end
      for (int i = 0; i < 40 && exp1.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (exp1.size() != 0) begin
         miscompares++;
         $display("FAIL iso_s1_drain got %0d left expected 0", exp1.size());
      end
      for (int k = 0; k < 2; k++) begin
         if (ar_log.size() != 0) got = ar_log.pop_front(); else got = 'x;
         vectors++;
         if (got !== ((k == 0) ? 32'h0000_5000 : 32'h0000_6000)) begin
            miscompares++;
            $display("FAIL iso_ar_log%0d got %h", k, got);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      s0_if.ARVALID = 1'b0; s0_if.ARADDR = '0; s0_if.RREADY = 1'b1;
      s1_if.ARVALID = 1'b0; s1_if.ARADDR = '0; s1_if.RREADY = 1'b1;
      m_if.ARREADY = 1'b0;
      test_reset();
      test_single_read();
      test_tie();
      test_backpressure();
      test_reset_in_data();
      test_isolation();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
